// File: rtl/bist_march_ctrl_128x8.sv
// March C- BIST controller for port 0 of a 128x8 SRAM wrapper.
// Passes a functional requester through when idle; owns the port while testing.
module bist_march_ctrl_128x8 #(
  parameter int              ADDR_W = 7,
  parameter int              DATA_W = 8,
  parameter int              DEPTH  = 128,
  parameter logic [DATA_W-1:0] BG   = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] func_A,
  input  logic [DATA_W-1:0] func_D,
  input  logic              func_WE,
  input  logic              func_CE,
  output logic [DATA_W-1:0] func_Q,
  output logic [ADDR_W-1:0] A0,
  output logic [DATA_W-1:0] D0,
  output logic              WE0,
  output logic              CE0,
  output logic [DATA_W-1:0] WEM0,
  input  logic [DATA_W-1:0] Q0,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [7:0]        err_cnt,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [3:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              ph;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_exp;

  logic              is_march, paired, down, next_down;
  logic              bist_we, bist_rd, last_addr, elem_end, start_ok;
  logic [DATA_W-1:0] bist_d, bist_exp;

  always_comb begin
    is_march  = (state >= S_M0) && (state <= S_M5);
    paired    = (state >= S_M1) && (state <= S_M4);
    down      = (state == S_M3) || (state == S_M4);
    next_down = (state == S_M2) || (state == S_M3);
    // M0 is write-only; paired elements read on ph=0 and write on ph=1.
    bist_we   = (state == S_M0) || (paired && ph);
    bist_rd   = is_march && !bist_we;
    bist_d    = ((state == S_M1) || (state == S_M3)) ? ~BG : BG;
    bist_exp  = ((state == S_M2) || (state == S_M4)) ? ~BG : BG;
    last_addr = down ? (addr == '0) : (addr == LAST);
    elem_end  = last_addr && (!paired || ph);
    start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_comb begin
    busy      = is_march || (state == S_DRAIN);
    done      = (state == S_DONE);
    dbg_state = state;
    func_Q    = Q0;
    WEM0      = '1;
    A0        = busy ? addr   : func_A;
    D0        = busy ? bist_d : func_D;
    WE0       = RST ? 1'b0 : (busy ? bist_we  : func_WE);
    CE0       = RST ? 1'b0 : (busy ? is_march : func_CE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      addr  <= '0;
      ph    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state <= S_M0;
            addr  <= '0;
            ph    <= 1'b0;
          end
        end
        S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
          if (paired && !ph) begin
            ph <= 1'b1;
          end else begin
            ph <= 1'b0;
            if (elem_end) begin
              state <= state + 4'd1;
              addr  <= next_down ? LAST : '0;
            end else begin
              addr  <= down ? addr - 1'b1 : addr + 1'b1;
            end
          end
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after issue, so compare against the registered expectation.
  always_ff @(posedge CLK) begin
    if (RST || start_ok) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_exp  <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_cnt   <= '0;
    end else begin
      pend      <= bist_rd;
      pend_addr <= addr;
      pend_exp  <= bist_exp;
      if (pend && (Q0 != pend_exp)) begin
        fail <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (!fail) begin
          fail_addr <= pend_addr;
          fail_exp  <= pend_exp;
          fail_got  <= Q0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bist_march_ctrl_128x8.sv
// Bench for bist_march_ctrl_128x8: SRAM model with injectable faults and an
// algorithmic March C- reference that predicts the op stream and fail capture.
module tb_bist_march_ctrl_128x8;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int N  = 128;
  localparam logic [DW-1:0] BGV = 8'h00;

  logic          CLK = 1'b0;
  logic          RST, start, func_WE, func_CE;
  logic [AW-1:0] func_A, A0, fail_addr;
  logic [DW-1:0] func_D, func_Q, D0, WEM0, fail_exp, fail_got;
  logic [DW-1:0] Q0 = '0;
  logic          WE0, CE0, busy, done, fail;
  logic [7:0]    err_cnt;
  logic [3:0]    dbg_state;

  bist_march_ctrl_128x8 dut (
    .CLK(CLK), .RST(RST), .start(start),
    .func_A(func_A), .func_D(func_D), .func_WE(func_WE), .func_CE(func_CE),
    .func_Q(func_Q), .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0), .WEM0(WEM0),
    .Q0(Q0), .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_got(fail_got), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // SRAM with faults: stuck-at bit on read, write alias, or inverted read of every word
  logic [DW-1:0] mem [N];
  bit sa_en, sa_val, al_en, inv_all;
  int sa_addr, sa_bit, al_src, al_dst;

  function automatic logic [DW-1:0] faulty_read(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
    if (inv_all) r = ~r;
    return r;
  endfunction

  always @(posedge CLK) begin
    if (CE0 && WE0) begin
      mem[A0] <= D0;
      if (al_en && int'(A0) == al_src) mem[al_dst] <= D0;
    end
    if (CE0 && !WE0) Q0 <= faulty_read(mem[A0], int'(A0));
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+DW+1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // March C- as a table: direction, read pattern (-1 none), write pattern (-1 none)
  bit el_down [6] = '{0, 0, 0, 1, 1, 0};
  int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
  int el_wr   [6] = '{0, 1, 0, 1, 0, -1};

  bit            e_fail;
  int            e_addr, e_err;
  logic [DW-1:0] e_exp, e_got;

  task automatic predict();
    logic [DW-1:0] pm [N];
    logic [DW-1:0] pat, v;
    int a;
    exp_q.delete();
    e_fail = 0; e_addr = 0; e_err = 0; e_exp = '0; e_got = '0;
    for (int i = 0; i < N; i++) pm[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = el_down[e] ? N - 1 - i : i;
        if (el_rd[e] >= 0) begin
          pat = (el_rd[e] == 1) ? ~BGV : BGV;
          exp_q.push_back({1'b1, 1'b0, AW'(a), DW'(0)});
          v = faulty_read(pm[a], a);
          if (v !== pat) begin
            if (!e_fail) begin e_addr = a; e_exp = pat; e_got = v; end
            e_fail = 1;
            if (e_err < 255) e_err++;
          end
        end
        if (el_wr[e] >= 0) begin
          pat = (el_wr[e] == 1) ? ~BGV : BGV;
          exp_q.push_back({1'b1, 1'b1, AW'(a), pat});
          pm[a] = pat;
          if (al_en && a == al_src) pm[al_dst] = pat;
        end
      end
    end
  endtask

  // driver tasks
  task automatic clear_faults();
    sa_en = 0; al_en = 0; inv_all = 0;
    sa_addr = 0; sa_bit = 0; sa_val = 0; al_src = 0; al_dst = 0;
  endtask

  task automatic set_stuck(input int a, input int b, input bit val);
    clear_faults();
    sa_en = 1; sa_addr = a; sa_bit = b; sa_val = val;
  endtask

  task automatic set_alias(input int src, input int dst);
    clear_faults();
    al_en = 1; al_src = src; al_dst = dst;
  endtask

  task automatic run_march(input bit hold);
    logic [AW+DW+1:0] exp_op, obs;
    predict();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); if (!hold) start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_fail_clr", 32'(fail), 32'd0);
    check("start_err_clr", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 10 * N; k++) begin
      if (k > 0) @(negedge CLK);
      exp_op = exp_q.pop_front();
      obs = {CE0, WE0, A0, WE0 ? D0 : DW'(0)};
      check("op", 32'(obs), 32'(exp_op));
    end
    @(negedge CLK); start = 1'b0;
    check("drain", 32'({busy, CE0, done}), 32'b100);
    @(negedge CLK);
    check("done", 32'({done, busy}), 32'b10);
    check("fail", 32'(fail), 32'(e_fail));
    check("fail_addr", 32'(fail_addr), 32'(e_addr));
    check("fail_exp", 32'(fail_exp), 32'(e_exp));
    check("fail_got", 32'(fail_got), 32'(e_got));
    check("err_cnt", 32'(err_cnt), 32'(e_err));
  endtask

  initial begin
    logic [DW-1:0] fm [N];
    int ra [4];
    logic [DW-1:0] rd [4];

    clear_faults();
    for (int i = 0; i < N; i++) mem[i] = '0;
    RST = 1'b1; start = 1'b0;
    func_A = 7'h2A; func_D = 8'h5C; func_WE = 1'b1; func_CE = 1'b1;

    // reset holds the port quiet even with a functional request present
    @(negedge CLK);
    check("rst_ce", 32'(CE0), 32'd0);
    check("rst_we", 32'(WE0), 32'd0);
    @(negedge CLK); RST = 1'b0; func_CE = 1'b0; func_WE = 1'b0;
    #1;
    check("rst_flags", 32'({busy, done, fail}), 32'd0);
    check("rst_capture", 32'({fail_addr, fail_exp, fail_got, err_cnt}), 32'd0);
    check("wem", 32'(WEM0), 32'hFF);

    // functional pass-through write then read
    @(negedge CLK);
    func_CE = 1'b1; func_WE = 1'b1; func_A = 7'h2A; func_D = 8'h5C;
    #1;
    check("pt_port", 32'({A0, D0, WE0, CE0}), 32'({7'h2A, 8'h5C, 1'b1, 1'b1}));
    @(negedge CLK); func_WE = 1'b0;
    @(negedge CLK);
    check("pt_q", 32'(func_Q), 32'h5C);

    // random functional traffic
    for (int i = 0; i < N; i++) fm[i] = mem[i];
    for (int i = 0; i < 4; i++) begin
      ra[i] = $urandom_range(N - 1); rd[i] = DW'($urandom);
      func_WE = 1'b1; func_A = AW'(ra[i]); func_D = rd[i]; fm[ra[i]] = rd[i];
      @(negedge CLK);
    end
    func_WE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      func_A = AW'(ra[i]);
      @(negedge CLK);
      check("pt_rand_q", 32'(func_Q), 32'(fm[ra[i]]));
    end
    func_CE = 1'b0;

    // fault-free run
    run_march(1'b0);

    // stuck-at-1 bit 3 at 0x05
    set_stuck(5, 3, 1'b1);
    run_march(1'b0);
    check("sa_directed", 32'({fail, fail_addr, fail_exp, fail_got, err_cnt}),
          32'({1'b1, 7'h05, 8'h00, 8'h08, 8'd3}));

    // write to 0x11 also lands in 0x10
    set_alias(8'h11, 8'h10);
    run_march(1'b0);
    check("alias_directed", 32'({fail, fail_addr, fail_exp, fail_got}),
          32'({1'b1, 7'h10, 8'h00, 8'hFF}));

    // randomized faults
    for (int r = 0; r < 3; r++) begin
      if ($urandom_range(1) == 0)
        set_stuck($urandom_range(N - 1), $urandom_range(DW - 1), 1'($urandom_range(1)));
      else
        set_alias($urandom_range(N - 1), $urandom_range(N - 1));
      run_march(1'($urandom_range(1)));
    end

    // every read wrong: error count saturates
    clear_faults(); inv_all = 1;
    run_march(1'b0);

    // start held through a clean run, then a restart from DONE
    clear_faults();
    run_march(1'b1);
    run_march(1'b0);

    // reset in the middle of M2
    set_stuck(5, 3, 1'b1);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (3 * N + 5) @(negedge CLK);
    check("mid_fail", 32'({busy, fail}), 32'b11);
    RST = 1'b1; func_CE = 1'b1; func_WE = 1'b0;
    #1;
    check("mid_rst_ce", 32'({CE0, WE0}), 32'd0);
    @(negedge CLK); RST = 1'b0;
    #1;
    check("abort_flags", 32'({busy, done, fail, err_cnt}), 32'd0);
    check("abort_ce_follow", 32'(CE0), 32'd1);
    func_CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_quiet", 32'({busy, CE0}), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
